// File: rtl/mat_if.sv
// Pipeline-side bundle for the matrix execute unit: ID/EX operands in, writeback/stall status out.
interface mat_if;
   logic         ex_mat_start;
   logic [2:0]   ex_func3_code;
   logic [127:0] ex_matrix_data;
   logic [31:0]  ex_regs_data1;
   logic [31:0]  ex_regs_data2;
   logic [4:0]   ex_rd;
   logic         mat_kill;
   logic         mat_busy;
   logic         mat_wb_en;
   logic [4:0]   mat_rd;
   logic [127:0] mat_result;
   logic         mat_illegal;

   modport master (
      output ex_mat_start, ex_func3_code, ex_matrix_data, ex_regs_data1,
             ex_regs_data2, ex_rd, mat_kill,
      input  mat_busy, mat_wb_en, mat_rd, mat_result, mat_illegal
   );

   modport slave (
      input  ex_mat_start, ex_func3_code, ex_matrix_data, ex_regs_data1,
             ex_regs_data2, ex_rd, mat_kill,
      output mat_busy, mat_wb_en, mat_rd, mat_result, mat_illegal
   );
endinterface

// File: rtl/matrix_ex_unit.sv
// Matrix execute unit: 4x4 int8 matrix-vector multiply, transpose and scale, one result row per cycle.
// Build option: define MAT_SAT_EN to saturate SCALE results to [-128,127] instead of wrapping.
//
// state | meaning
// IDLE  | waiting for ex_mat_start; operands latched on accept
// RUN   | computing result row row_q (0..3)
// DONE  | one-cycle writeback strobe, start ignored
module matrix_ex_unit (
   input logic clk,
   input logic rst,
   mat_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t       state_q, state_d;
   logic         accept, busy_c;
   logic [1:0]   row_q, op_q;
   logic [127:0] a_q;
   logic [31:0]  x_q;
   logic [7:0]   s_q;
   logic [4:0]   rd_q;
   logic [95:0]  work_q;
   logic [127:0] result_q;
   logic [4:0]   mat_rd_q;
   logic         wb_q, ill_q;
   logic [31:0]  row_val;
   logic         unused_bits;

   assign unused_bits = &{1'b0, bus.ex_regs_data2[31:8]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      busy_c  = 1'b0;
      case (state_q)
         IDLE: if (bus.ex_mat_start) begin
            accept  = 1'b1;
            busy_c  = 1'b1;
            state_d = bus.ex_func3_code[2] ? DONE : RUN;
         end
         RUN: begin
            busy_c = 1'b1;
            if (bus.mat_kill)       state_d = IDLE;
            else if (row_q == 2'd3) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   logic [7:0]         a_e, x_e, t_e;
   logic signed [15:0] prod_s, prod_k;
   logic [15:0]        prod_u;
   logic signed [17:0] acc_s;
   logic [17:0]        acc_u;
   logic [31:0]        tr_row, sc_row;

   always_comb begin
      a_e    = '0;
      x_e    = '0;
      t_e    = '0;
      prod_s = '0;
      prod_k = '0;
      prod_u = '0;
      acc_s  = '0;
      acc_u  = '0;
      tr_row = '0;
      sc_row = '0;
      for (int c = 0; c < 4; c++) begin
         a_e    = a_q[32*int'(row_q) + 8*c +: 8];
         x_e    = x_q[8*c +: 8];
         t_e    = a_q[32*c + 8*int'(row_q) +: 8];
         prod_s = $signed({{8{a_e[7]}}, a_e}) * $signed({{8{x_e[7]}}, x_e});
         prod_u = {8'b0, a_e} * {8'b0, x_e};
         prod_k = $signed({{8{a_e[7]}}, a_e}) * $signed({{8{s_q[7]}}, s_q});
         acc_s  = acc_s + {{2{prod_s[15]}}, prod_s};
         acc_u  = acc_u + {2'b0, prod_u};
         tr_row[8*c +: 8] = t_e;
`ifdef MAT_SAT_EN
         if (prod_k > 16'sd127)       sc_row[8*c +: 8] = 8'h7F;
         else if (prod_k < -16'sd128) sc_row[8*c +: 8] = 8'h80;
         else                         sc_row[8*c +: 8] = prod_k[7:0];
`else
         sc_row[8*c +: 8] = prod_k[7:0];
`endif
      end
      case (op_q)
         2'b00:   row_val = {{14{acc_s[17]}}, acc_s};
         2'b01:   row_val = {14'b0, acc_u};
         2'b10:   row_val = tr_row;
         default: row_val = sc_row;
      endcase
   end

   // Rows shift in from the top so row 0 ends in the low word; mat_result only
   // changes on completion, which keeps a killed operation invisible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         x_q      <= '0;
         s_q      <= '0;
         rd_q     <= '0;
         work_q   <= '0;
         result_q <= '0;
         mat_rd_q <= '0;
         wb_q     <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         wb_q  <= 1'b0;
         ill_q <= 1'b0;
         if (accept) begin
            a_q   <= bus.ex_matrix_data;
            x_q   <= bus.ex_regs_data1;
            s_q   <= bus.ex_regs_data2[7:0];
            op_q  <= bus.ex_func3_code[1:0];
            rd_q  <= bus.ex_rd;
            row_q <= '0;
            if (bus.ex_func3_code[2]) begin
               result_q <= '0;
               mat_rd_q <= bus.ex_rd;
               wb_q     <= 1'b1;
               ill_q    <= 1'b1;
            end
         end else if (state_q == RUN && !bus.mat_kill) begin
            if (row_q == 2'd3) begin
               result_q <= {row_val, work_q};
               mat_rd_q <= rd_q;
               wb_q     <= 1'b1;
            end else begin
               work_q <= {row_val, work_q[95:32]};
            end
            row_q <= row_q + 2'd1;
         end
      end
   end

   assign bus.mat_busy    = rst & busy_c;
   assign bus.mat_wb_en   = wb_q;
   assign bus.mat_illegal = ill_q;
   assign bus.mat_rd      = mat_rd_q;
   assign bus.mat_result  = result_q;
endmodule
